// File: rtl/generador_pulsos.sv
// Pulse-train transmitter: on start emits N=valor single-cycle pulses spaced by GAP idle cycles,
// then a one-cycle fin. Optional abort input enabled by defining GENPULSOS_ABORTAR_EN.
module generador_pulsos #(
    parameter int unsigned GAP = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] valor,
`ifdef GENPULSOS_ABORTAR_EN
    input  logic       abortar,
`endif
    output logic       pulso,
    output logic [3:0] cuenta,
    output logic       ocupado,
    output logic       fin
);

    typedef enum logic [1:0] {StReposo, StPulso, StEspera, StFin} estado_t;

    // Gap counter counts down from GAP-1 to 0, so ESPERA lasts exactly GAP cycles.
    localparam bit         HayGap   = (GAP != 0);
    localparam logic [3:0] GapCarga = HayGap ? 4'(GAP - 1) : 4'd0;

    estado_t    estado_q;
    logic [2:0] n_q;
    logic [3:0] gap_q;
    logic [3:0] cuenta_q;
    logic       pulso_q;
    logic       ocupado_q;
    logic       fin_q;
    logic       abortar_int;
    logic       ultimo;

`ifdef GENPULSOS_ABORTAR_EN
    assign abortar_int = abortar;
`else
    assign abortar_int = 1'b0;
`endif

    assign ultimo = (cuenta_q == {1'b0, n_q});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q  <= StReposo;
            n_q       <= 3'd0;
            gap_q     <= 4'd0;
            cuenta_q  <= 4'd0;
            pulso_q   <= 1'b0;
            ocupado_q <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            pulso_q <= 1'b0;
            fin_q   <= 1'b0;
            case (estado_q)
                StReposo: begin
                    if (start) begin
                        n_q       <= valor;
                        ocupado_q <= 1'b1;
                        if (valor != 3'd0) begin
                            estado_q <= StPulso;
                            pulso_q  <= 1'b1;
                            cuenta_q <= 4'd1;
                        end else begin
                            estado_q <= StFin;
                            fin_q    <= 1'b1;
                            cuenta_q <= 4'd0;
                        end
                    end
                end
                StPulso: begin
                    if (abortar_int || ultimo) begin
                        estado_q <= StFin;
                        fin_q    <= 1'b1;
                    end else if (HayGap) begin
                        estado_q <= StEspera;
                        gap_q    <= GapCarga;
                    end else begin
                        pulso_q  <= 1'b1;
                        cuenta_q <= cuenta_q + 4'd1;
                    end
                end
                StEspera: begin
                    if (abortar_int) begin
                        estado_q <= StFin;
                        fin_q    <= 1'b1;
                    end else if (gap_q == 4'd0) begin
                        estado_q <= StPulso;
                        pulso_q  <= 1'b1;
                        cuenta_q <= cuenta_q + 4'd1;
                    end else begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
                StFin: begin
                    estado_q  <= StReposo;
                    ocupado_q <= 1'b0;
                end
                default: begin
                    estado_q  <= StReposo;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign pulso   = pulso_q;
    assign cuenta  = cuenta_q;
    assign ocupado = ocupado_q;
    assign fin     = fin_q;

endmodule
